register_16bit: RTL and testbench



---
 rtl/register_16bit_pkg.sv | 11 +
 rtl/register_16bit.sv | 34 +++
 tb/tb_register_16bit.sv | 139 +++++++++++++
 3 files changed

// File: rtl/register_16bit_pkg.sv
// Shared datapath definitions: FunSel encodings used by every register variant.
package register_16bit_pkg;

    localparam int REG_WIDTH = 16;

    localparam logic [1:0] FS_DEC  = 2'b00;
    localparam logic [1:0] FS_INC  = 2'b01;
    localparam logic [1:0] FS_LOAD = 2'b10;
    localparam logic [1:0] FS_CLR  = 2'b11;

endpackage

// File: rtl/register_16bit.sv
// General-purpose register with enable and 2-bit function select
// (decrement, increment, load, clear); Q is the state flop itself.
module register_16bit
    import register_16bit_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] I,
    input  logic             E,
    input  logic [1:0]       FunSel,
    output logic [WIDTH-1:0] Q
);

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = '0;

    // Reset outranks enable; arithmetic wraps modulo 2^WIDTH with no flags.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            Q <= ZERO;
        end else if (E) begin
            case (FunSel)
                FS_DEC:  Q <= Q - ONE;
                FS_INC:  Q <= Q + ONE;
                FS_LOAD: Q <= I;
                FS_CLR:  Q <= ZERO;
                default: Q <= Q;
            endcase
        end
    end

endmodule

// File: tb/tb_register_16bit.sv
// Directed self-checking bench for register_16bit.
module tb_register_16bit;
    import register_16bit_pkg::*;

    logic        Clock;
    logic        Reset;
    logic [15:0] I;
    logic        E;
    logic [1:0]  FunSel;
    logic [15:0] Q;

    int assertCount;
    int failCount;
    logic [15:0] exp_q[$];

    register_16bit #(.WIDTH(16)) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .I      (I),
        .E      (E),
        .FunSel (FunSel),
        .Q      (Q)
    );

    // Clock / reset block
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Driver: present inputs at the falling edge, step one rising edge, settle.
    task automatic applyOp(input logic rst, input logic en, input logic [1:0] fs,
                           input logic [15:0] din);
        @(negedge Clock);
        Reset  = rst;
        E      = en;
        FunSel = fs;
        I      = din;
        @(posedge Clock);
        #1;
    endtask

    // Scoreboard: expected value queued, then popped and compared against Q.
    task automatic checkQ(input string tag, input logic [15:0] expected);
        logic [15:0] want;
        exp_q.push_back(expected);
        want = exp_q.pop_front();
        assertCount++;
        assert (Q === want)
        else begin
            failCount++;
            $error("FAIL %s: Q=%h expected %h", tag, Q, want);
        end
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        Reset  = 1'b0;
        E      = 1'b0;
        FunSel = FS_DEC;
        I      = 16'h0000;

        // Reset
        applyOp(1'b0, 1'b0, FS_DEC, 16'h0000);
        applyOp(1'b0, 1'b1, FS_INC, 16'hAAAA);
        checkQ("reset", 16'h0000);

        // Hold
        applyOp(1'b1, 1'b1, FS_LOAD, 16'h0025);
        checkQ("load_0025", 16'h0025);
        applyOp(1'b1, 1'b0, FS_DEC, 16'h0072);
        checkQ("hold", 16'h0025);

        // Decrement / increment / disabled increment
        applyOp(1'b1, 1'b1, FS_DEC, 16'h0072);
        checkQ("dec", 16'h0024);
        applyOp(1'b1, 1'b1, FS_LOAD, 16'h0025);
        applyOp(1'b1, 1'b1, FS_INC, 16'h0000);
        checkQ("inc", 16'h0026);
        applyOp(1'b1, 1'b1, FS_LOAD, 16'h0025);
        applyOp(1'b1, 1'b0, FS_INC, 16'h0000);
        checkQ("inc_disabled", 16'h0025);

        // Load and clear
        applyOp(1'b1, 1'b1, FS_LOAD, 16'hBEEF);
        checkQ("load_beef", 16'hBEEF);
        applyOp(1'b1, 1'b1, FS_CLR, 16'h1111);
        checkQ("clear", 16'h0000);

        // Wrap-around
        applyOp(1'b1, 1'b1, FS_DEC, 16'h0000);
        checkQ("dec_wrap", 16'hFFFF);
        applyOp(1'b1, 1'b1, FS_INC, 16'h0000);
        checkQ("inc_wrap", 16'h0000);

        // Reset priority and release
        applyOp(1'b1, 1'b1, FS_LOAD, 16'h1234);
        checkQ("load_1234", 16'h1234);
        applyOp(1'b0, 1'b1, FS_LOAD, 16'h5555);
        checkQ("reset_priority", 16'h0000);
        applyOp(1'b1, 1'b1, FS_LOAD, 16'h5555);
        checkQ("reset_release", 16'h5555);

        // Back-to-back increments
        applyOp(1'b1, 1'b1, FS_INC, 16'h0000);
        checkQ("b2b_inc1", 16'h5556);
        applyOp(1'b1, 1'b1, FS_INC, 16'h0000);
        checkQ("b2b_inc2", 16'h5557);
        applyOp(1'b1, 1'b1, FS_DEC, 16'h0000);
        checkQ("b2b_dec", 16'h5556);

        // Between-edge activity: inputs and reset wiggle with no rising edge
        E = 1'b1; FunSel = FS_LOAD; I = 16'hDEAD;
        #1;
        FunSel = FS_CLR; I = 16'h0F0F;
        #1;
        Reset = 1'b0; FunSel = FS_INC;
        #1;
        checkQ("between_edges", 16'h5556);
        // Leave the edge harmless: reset released, enable low
        Reset = 1'b1; E = 1'b0;
        @(posedge Clock);
        #1;
        checkQ("after_wiggle_edge", 16'h5556);

        // Load a second pattern and decrement through a borrow chain
        applyOp(1'b1, 1'b1, FS_LOAD, 16'h8000);
        checkQ("load_8000", 16'h8000);
        applyOp(1'b1, 1'b1, FS_DEC, 16'h0000);
        checkQ("dec_borrow", 16'h7FFF);
        applyOp(1'b1, 1'b1, FS_INC, 16'h0000);
        checkQ("inc_carry", 16'h8000);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
